// File: rtl/fifo_btn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_btn_ctrl
//  Brief    : Push-button front end for the board FIFO: debounces the write and
//             read buttons, queues presses and issues single-cycle strobes.
//             Optional macro FIFO_CTRL_REJECT_CNT_EN adds the REJ_CNT output.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_btn_ctrl #(
    parameter int DATA_W     = 8,
    parameter int DEB_CYCLES = 16,
    parameter int READ_LAT   = 1,
    parameter int OCC_W      = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              BTN_WRITE,
    input  logic              BTN_READ,
    input  logic [DATA_W-1:0] DATA_INPUT,
    input  logic              FIFO_FULL,
    input  logic              FIFO_EMPTY,
    input  logic [DATA_W-1:0] FIFO_DATA_OUT,
    output logic              FIFO_WR,
    output logic              FIFO_RD,
    output logic [DATA_W-1:0] FIFO_DATA_IN,
    output logic [DATA_W-1:0] DISP_DATA,
    output logic [OCC_W-1:0]  OCCUPANCY,
    output logic              BUSY,
    output logic              REJECT
`ifdef FIFO_CTRL_REJECT_CNT_EN
    ,
    output logic [7:0]        REJ_CNT
`endif
);

    localparam logic [15:0] C_DEB_LAST = 16'(DEB_CYCLES - 1);
    localparam logic [1:0]  C_RD_LAT   = 2'(READ_LAT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_CAP  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        w_btn_raw;
    logic [1:0]        w_press;
    logic              r_pend_wr;
    logic              r_pend_rd;
    logic [DATA_W-1:0] r_wr_hold;
    logic [DATA_W-1:0] r_data_in;
    logic [DATA_W-1:0] r_disp;
    logic [OCC_W-1:0]  r_occ;
    logic              r_reject;
    logic [1:0]        r_lat_cnt;
    logic              w_reject;
    logic              w_clr_wr;
    logic              w_clr_rd;
    logic              w_wr_go;
    logic              w_cap_done;

    assign w_btn_raw = {BTN_READ, BTN_WRITE};

    // Index 0 is the write button, index 1 the read button.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic        r_sync1;
            logic        r_sync2;
            logic        r_level;
            logic        r_level_d;
            logic [15:0] r_cnt;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_sync1   <= 1'b0;
                    r_sync2   <= 1'b0;
                    r_level   <= 1'b0;
                    r_level_d <= 1'b0;
                    r_cnt     <= '0;
                end else begin
                    r_sync1   <= w_btn_raw[gi];
                    r_sync2   <= r_sync1;
                    r_level_d <= r_level;
                    if (r_sync2 != r_level) begin
                        if (r_cnt == C_DEB_LAST) begin
                            r_level <= r_sync2;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
            end

            assign w_press[gi] = r_level & ~r_level_d;
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_reject    = 1'b0;
        w_clr_wr    = 1'b0;
        w_clr_rd    = 1'b0;
        w_wr_go     = 1'b0;
        w_cap_done  = 1'b0;
        FIFO_WR     = 1'b0;
        FIFO_RD     = 1'b0;
        BUSY        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                // Writes win over reads; flags are only looked at here.
                if (r_pend_wr) begin
                    if (FIFO_FULL) begin
                        w_reject = 1'b1;
                        w_clr_wr = 1'b1;
                    end else begin
                        w_wr_go     = 1'b1;
                        w_state_nxt = S_WR;
                    end
                end else if (r_pend_rd) begin
                    if (FIFO_EMPTY) begin
                        w_reject = 1'b1;
                        w_clr_rd = 1'b1;
                    end else begin
                        w_state_nxt = S_RD;
                    end
                end
            end
            S_WR: begin
                FIFO_WR     = 1'b1;
                w_clr_wr    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_RD: begin
                FIFO_RD     = 1'b1;
                w_clr_rd    = 1'b1;
                w_state_nxt = S_CAP;
            end
            S_CAP: begin
                if (r_lat_cnt == C_RD_LAT) begin
                    w_cap_done  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pend_wr <= 1'b0;
            r_pend_rd <= 1'b0;
            r_wr_hold <= '0;
            r_data_in <= '0;
            r_disp    <= '0;
            r_occ     <= '0;
            r_reject  <= 1'b0;
            r_lat_cnt <= '0;
        end else begin
            // A press arriving while its request is still pending is dropped.
            if (w_press[0] && !r_pend_wr) begin
                r_pend_wr <= 1'b1;
                r_wr_hold <= DATA_INPUT;
            end else if (w_clr_wr) begin
                r_pend_wr <= 1'b0;
            end
            if (w_press[1] && !r_pend_rd) r_pend_rd <= 1'b1;
            else if (w_clr_rd)            r_pend_rd <= 1'b0;

            r_reject <= w_reject;
            if (w_wr_go) r_data_in <= r_wr_hold;

            // The RD cycle itself counts as the first latency cycle.
            if (r_state == S_RD)       r_lat_cnt <= 2'd1;
            else if (r_state == S_CAP) r_lat_cnt <= r_lat_cnt + 2'd1;

            if (r_state == S_WR && r_occ != '1) r_occ <= r_occ + OCC_W'(1);
            if (w_cap_done) begin
                r_disp <= FIFO_DATA_OUT;
                if (r_occ != '0) r_occ <= r_occ - OCC_W'(1);
            end
        end
    end

    assign FIFO_DATA_IN = r_data_in;
    assign DISP_DATA    = r_disp;
    assign OCCUPANCY    = r_occ;
    assign REJECT       = r_reject;

`ifdef FIFO_CTRL_REJECT_CNT_EN
    logic [7:0] r_rej_cnt;

    always_ff @(posedge CLK) begin
        if (RST)                              r_rej_cnt <= 8'd0;
        else if (w_reject && r_rej_cnt != 8'hFF) r_rej_cnt <= r_rej_cnt + 8'd1;
    end

    assign REJ_CNT = r_rej_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_btn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_btn_ctrl
//  Brief    : Self-checking bench for fifo_btn_ctrl with a queue-based FIFO
//             and an event-level reference model of the controller.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_btn_ctrl;

    localparam int DEB   = 4;
    localparam int RL    = 1;
    localparam int DEPTH = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       BTN_WRITE = 1'b0;
    logic       BTN_READ = 1'b0;
    logic [7:0] DATA_INPUT = 8'h00;
    logic       FIFO_FULL, FIFO_EMPTY;
    logic [7:0] FIFO_DATA_OUT;
    logic       FIFO_WR, FIFO_RD, BUSY, REJECT;
    logic [7:0] FIFO_DATA_IN, DISP_DATA;
    logic [4:0] OCCUPANCY;
`ifdef FIFO_CTRL_REJECT_CNT_EN
    logic [7:0] REJ_CNT;
`endif

    fifo_btn_ctrl #(.DATA_W(8), .DEB_CYCLES(DEB), .READ_LAT(RL), .OCC_W(5)) dut (
        .CLK(CLK), .RST(RST), .BTN_WRITE(BTN_WRITE), .BTN_READ(BTN_READ),
        .DATA_INPUT(DATA_INPUT), .FIFO_FULL(FIFO_FULL), .FIFO_EMPTY(FIFO_EMPTY),
        .FIFO_DATA_OUT(FIFO_DATA_OUT), .FIFO_WR(FIFO_WR), .FIFO_RD(FIFO_RD),
        .FIFO_DATA_IN(FIFO_DATA_IN), .DISP_DATA(DISP_DATA), .OCCUPANCY(OCCUPANCY),
        .BUSY(BUSY), .REJECT(REJECT)
`ifdef FIFO_CTRL_REJECT_CNT_EN
        , .REJ_CNT(REJ_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Board FIFO stand-in, one cycle read latency, shares RST.
    logic [7:0] fifo_q[$];
    int         fcount = 0;
    logic [7:0] fdout = 8'h00;
    logic       force_full = 1'b0;

    always @(posedge CLK) begin
        if (RST) begin
            fifo_q.delete();
            fcount <= 0;
            fdout  <= 8'h00;
        end else begin
            if (FIFO_WR) begin
                fifo_q.push_back(FIFO_DATA_IN);
                fcount <= fcount + 1;
            end
            if (FIFO_RD && fifo_q.size() > 0) begin
                fdout  <= fifo_q.pop_front();
                fcount <= fcount - 1;
            end
        end
    end

    assign FIFO_FULL     = force_full || (fcount >= DEPTH);
    assign FIFO_EMPTY    = (fcount == 0);
    assign FIFO_DATA_OUT = fdout;

    // Reference model: presses become events with a fixed delay, requests are
    // served one per idle slot with write priority.
    logic       m_valid = 1'b0;
    int         n, m_idle_from, m_wr_done, m_rd_clr, m_cap_at, m_occ;
    int         m_run[2];
    int         m_due[2];
    logic       m_lvl[2];
    logic       m_pw, m_pr;
    logic [7:0] m_hold, m_rd_word;
    logic [7:0] m_q[$];
    logic       e_wr, e_rd, e_rej, e_busy;
    logic [7:0] e_din, e_disp;
    logic [4:0] e_occ;

    always @(posedge CLK) begin : p_model
        logic clr_w, clr_r, raw;
        if (RST) begin
            m_valid = 1'b1;
            n = 0; m_idle_from = 0; m_wr_done = -1; m_rd_clr = -1; m_cap_at = -1;
            for (int b = 0; b < 2; b++) begin
                m_run[b] = 0; m_due[b] = -1; m_lvl[b] = 1'b0;
            end
            m_pw = 1'b0; m_pr = 1'b0; m_hold = 8'h00; m_rd_word = 8'h00;
            m_q.delete(); m_occ = 0;
            e_wr = 1'b0; e_rd = 1'b0; e_rej = 1'b0; e_busy = 1'b0;
            e_din = 8'h00; e_disp = 8'h00; e_occ = 5'd0;
        end else begin
            n++;
            clr_w = 1'b0; clr_r = 1'b0;
            e_wr = 1'b0; e_rd = 1'b0; e_rej = 1'b0;
            if (n - 1 >= m_idle_from) begin
                if (m_pw) begin
                    if (force_full || m_q.size() >= DEPTH) begin
                        e_rej = 1'b1; clr_w = 1'b1;
                    end else begin
                        e_wr = 1'b1; e_din = m_hold; m_q.push_back(m_hold);
                        m_idle_from = n + 1; m_wr_done = n + 1;
                    end
                end else if (m_pr) begin
                    if (m_q.size() == 0) begin
                        e_rej = 1'b1; clr_r = 1'b1;
                    end else begin
                        e_rd = 1'b1; m_rd_word = m_q.pop_front();
                        m_idle_from = n + 1 + RL; m_rd_clr = n + 1; m_cap_at = n + 1 + RL;
                    end
                end
            end
            if (n == m_wr_done) begin
                if (m_occ < 31) m_occ++;
                clr_w = 1'b1;
            end
            if (n == m_rd_clr) clr_r = 1'b1;
            if (n == m_cap_at) begin
                e_disp = m_rd_word;
                if (m_occ > 0) m_occ--;
            end
            if (n == m_due[0] && !m_pw) begin m_pw = 1'b1; m_hold = DATA_INPUT; end
            if (n == m_due[1] && !m_pr) m_pr = 1'b1;
            for (int b = 0; b < 2; b++) begin
                raw = (b == 0) ? BTN_WRITE : BTN_READ;
                if (raw != m_lvl[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DEB) begin
                        m_lvl[b] = raw; m_run[b] = 0;
                        if (raw) m_due[b] = n + 3;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            if (clr_w) m_pw = 1'b0;
            if (clr_r) m_pr = 1'b0;
            e_occ  = 5'(m_occ);
            e_busy = (n < m_idle_from);
        end
    end

    int wr_cnt = 0, rd_cnt = 0, rej_cnt = 0;
    int last_wr_edge = 0, last_rd_edge = 0, press_edge = 0;

    always @(negedge CLK) begin
        if (m_valid) begin
            check("fifo_wr",      FIFO_WR,      e_wr);
            check("fifo_rd",      FIFO_RD,      e_rd);
            check("reject",       REJECT,       e_rej);
            check("busy",         BUSY,         e_busy);
            check("fifo_data_in", FIFO_DATA_IN, e_din);
            check("disp_data",    DISP_DATA,    e_disp);
            check("occupancy",    OCCUPANCY,    e_occ);
        end
        if (FIFO_WR) begin wr_cnt++; last_wr_edge = cyc; end
        if (FIFO_RD) begin rd_cnt++; last_rd_edge = cyc; end
        if (REJECT)  rej_cnt++;
    end

    task automatic press(input logic wr, input logic rd, input int hold, input int post);
        @(negedge CLK);
        BTN_WRITE  = wr;
        BTN_READ   = rd;
        press_edge = cyc + 1;
        repeat (hold) @(posedge CLK);
        @(negedge CLK);
        BTN_WRITE = 1'b0;
        BTN_READ  = 1'b0;
        repeat (post) @(negedge CLK);
    endtask

    task automatic reset_dut();
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin : p_stim
        logic found;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        check("rst_busy", BUSY, 1'b0);
        check("rst_occ",  OCCUPANCY, 5'd0);
        check("rst_disp", DISP_DATA, 8'h00);
        check("rst_wr",   FIFO_WR, 1'b0);

        DATA_INPUT = 8'h01;
        press(1'b1, 1'b0, 10, 20);
        check("t1_latency", 32'(last_wr_edge - press_edge), 32'd7);
        check("t1_wr_cnt",  32'(wr_cnt), 32'd1);
        check("t1_din",     FIFO_DATA_IN, 8'h01);
        check("t1_occ",     OCCUPANCY, 5'd1);
        check("t1_rej",     32'(rej_cnt), 32'd0);

        press(1'b1, 1'b0, 3, 20);
        check("t2_wr_cnt", 32'(wr_cnt), 32'd1);
        check("t2_occ",    OCCUPANCY, 5'd1);

        DATA_INPUT = 8'h02; press(1'b1, 1'b0, 10, 20);
        DATA_INPUT = 8'h04; press(1'b1, 1'b0, 10, 20);
        DATA_INPUT = 8'h08; press(1'b1, 1'b0, 10, 20);
        press(1'b0, 1'b1, 10, 20);
        check("t3_disp1", DISP_DATA, 8'h01);
        press(1'b0, 1'b1, 10, 20);
        check("t3_disp2", DISP_DATA, 8'h02);
        DATA_INPUT = 8'h10; press(1'b1, 1'b0, 10, 20);
        DATA_INPUT = 8'h20; press(1'b1, 1'b0, 10, 20);
        check("t3_wr_cnt", 32'(wr_cnt), 32'd6);
        check("t3_rd_cnt", 32'(rd_cnt), 32'd2);
        check("t3_occ",    OCCUPANCY, 5'd4);

        reset_dut();
        press(1'b0, 1'b1, 10, 20);
        check("t4_rej_rd",  32'(rej_cnt), 32'd1);
        check("t4_rd_cnt",  32'(rd_cnt), 32'd2);
        check("t4_disp",    DISP_DATA, 8'h00);
        force_full = 1'b1;
        DATA_INPUT = 8'h77;
        press(1'b1, 1'b0, 10, 20);
        force_full = 1'b0;
        check("t4_rej_wr",  32'(rej_cnt), 32'd2);
        check("t4_wr_cnt",  32'(wr_cnt), 32'd6);

        DATA_INPUT = 8'hAA; press(1'b1, 1'b0, 10, 20);
        check("t5_occ_pre", OCCUPANCY, 5'd1);
        DATA_INPUT = 8'h55; press(1'b1, 1'b1, 10, 25);
        check("t5_gap",    32'(last_rd_edge - last_wr_edge), 32'd2);
        check("t5_occ",    OCCUPANCY, 5'd1);
        check("t5_disp",   DISP_DATA, 8'hAA);
        check("t5_wr_cnt", 32'(wr_cnt), 32'd8);
        check("t5_rd_cnt", 32'(rd_cnt), 32'd3);

        @(negedge CLK);
        BTN_READ = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (FIFO_RD) begin found = 1'b1; break; end
        end
        check("t6_rd_seen", found, 1'b1);
        @(negedge CLK);
        BTN_READ = 1'b0;
        check("t6_cap_busy", BUSY, 1'b1);
        check("t6_cap_rd",   FIFO_RD, 1'b0);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("t6_disp", DISP_DATA, 8'h00);
        check("t6_busy", BUSY, 1'b0);
        check("t6_occ",  OCCUPANCY, 5'd0);
        DATA_INPUT = 8'h33;
        press(1'b1, 1'b0, 10, 20);
        check("t6_din",    FIFO_DATA_IN, 8'h33);
        check("t6_occ2",   OCCUPANCY, 5'd1);
        check("t6_wr_cnt", 32'(wr_cnt), 32'd9);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_btn_ctrl.md
Name: fifo_btn_ctrl

Overview:
- Front-end controller that sequences the 8-bit board FIFO from the two push-buttons and the 8-bit switch bank.
- Debounces and edge-detects BTN_WRITE/BTN_READ and queues each press as a pending request.
- Arbitrates the pending requests onto the FIFO strobes as single-cycle pulses, refuses a write when FULL and a read when EMPTY, and latches each read word for the display.

Parameters:
DATA_W, 8, data width of switches, FIFO ports and display register
DEB_CYCLES, 16, consecutive stable synchronised samples needed to change a debounced button level (legal 2..65535)
READ_LAT, 1, cycles from FIFO_RD high until FIFO_DATA_OUT is valid (legal 1..3)
OCC_W, 5, width of OCCUPANCY counter

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  synchronous active-high reset
BTN_WRITE  in  1  raw asynchronous write button, high = pressed
BTN_READ  in  1  raw asynchronous read button, high = pressed
DATA_INPUT  in  DATA_W  switch value to be written
FIFO_FULL  in  1  FULL flag from the FIFO
FIFO_EMPTY  in  1  EMPTY flag from the FIFO
FIFO_DATA_OUT  in  DATA_W  FIFO read data
FIFO_WR  out  1  one-cycle write strobe to the FIFO
FIFO_RD  out  1  one-cycle read strobe to the FIFO
FIFO_DATA_IN  out  DATA_W  write data to the FIFO, held stable while FIFO_WR is high
DISP_DATA  out  DATA_W  last word read from the FIFO
OCCUPANCY  out  OCC_W  words written minus words read by this controller
BUSY  out  1  FSM not in IDLE
REJECT  out  1  one-cycle pulse when a request is refused (write while full, or read while empty)

Behaviour:
- Reset: on a CLK edge with RST=1, all outputs go to 0, synchronisers go to 0, debounced levels go to released, counters and pending flags clear, and the FSM goes to IDLE. This applies in any state: a strobe in flight drops at that edge and a pending capture is abandoned. The FIFO shares RST, so OCCUPANCY=0 stays consistent with it.
- Input path, per button:
  - 2-flop synchroniser.
  - Debouncer: the counter increments while the synchronised value differs from the debounced level and clears otherwise; at DEB_CYCLES the level flips.
  - Registered rising-edge detect of the debounced level sets pend_wr/pend_rd. Release edges are ignored.
- Write data capture: DATA_INPUT is captured into wr_hold in the same cycle pend_wr is set. A new press while pend_wr is still set is dropped and wr_hold is unchanged.
- Press-to-strobe latency: FIFO_WR/FIFO_RD rise DEB_CYCLES+3 edges after the first edge that samples the raw button high, provided the FSM is IDLE with no other pending request.
- FSM states: IDLE, WR, RD, CAP.
  - IDLE, pend_wr set: if FIFO_FULL, pulse REJECT, clear pend_wr and stay in IDLE. Otherwise go to WR.
  - IDLE, pend_rd set and pend_wr clear: if FIFO_EMPTY, pulse REJECT, clear pend_rd and stay in IDLE. Otherwise go to RD.
  - Priority: a write is served before a read. Only one request is serviced per visit to IDLE.
  - WR: FIFO_WR=1 and FIFO_DATA_IN=wr_hold for exactly one cycle. OCCUPANCY+1, saturating at all-ones. Clear pend_wr. Go to IDLE.
  - RD: FIFO_RD=1 for exactly one cycle. Clear pend_rd. Go to CAP.
  - CAP: wait READ_LAT cycles counted from the RD cycle, then DISP_DATA<=FIFO_DATA_OUT and OCCUPANCY-1 (floor 0). Go to IDLE.
- FIFO_DATA_IN holds its last value outside WR. DISP_DATA changes only in CAP.
- Flags: FULL/EMPTY are sampled in IDLE only, never in WR/RD.
- Strobe spacing: a strobe is never high two cycles in a row, and FIFO_WR and FIFO_RD are never high together.

Optional Feature:
- Macro: FIFO_CTRL_REJECT_CNT_EN.
- When defined: adds output REJ_CNT, 8 bits. It increments on every REJECT pulse, saturates at 0xFF, and clears on RST.
- When undefined: no REJ_CNT port and no counter logic. All other behaviour is identical.

Test Plan:
- DEB_CYCLES=4, DATA_INPUT=0x01, BTN_WRITE held 10 cycles -> FIFO_WR high exactly one cycle, 7 edges after the first sampled high, with FIFO_DATA_IN=0x01; OCCUPANCY=1; REJECT stays 0.
- BTN_WRITE glitch lasting 3 cycles -> no FIFO_WR, no pending flag, OCCUPANCY unchanged.
- Write 0x01,0x02,0x04,0x08, then two reads, then write 0x10,0x20 -> DISP_DATA=0x01 then 0x02; FIFO_WR count 6, FIFO_RD count 2; final OCCUPANCY=4.
- Read press with FIFO_EMPTY=1 -> REJECT one cycle, no FIFO_RD, DISP_DATA unchanged. Write press with FIFO_FULL=1 -> REJECT, no FIFO_WR.
- BTN_WRITE and BTN_READ rise on the same edge with the FIFO holding 1 word -> FIFO_WR first, FIFO_RD later with at least one idle cycle between, OCCUPANCY ends 1.
- RST asserted during CAP -> next edge: outputs 0, FSM IDLE, DISP_DATA=0x00 and not overwritten; a subsequent write press works normally.
